// File: rtl/restoring_divider_12by6_pkg.sv
// tree_arith_pkg: shared widths, divider FSM states and divide-by-zero result constants
package tree_arith_pkg;
    localparam int DW = 12;
    localparam int VW = 6;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    localparam logic [DW-1:0] DBZ_QUOT = 12'hFFF;
    localparam logic [VW-1:0] DBZ_REM = 6'h3F;
endpackage

// File: rtl/restoring_divider_12by6_if.sv
// restoring_divider_12by6_if: valid/ready operand and result channels of the divider
//   in_valid/in_ready/dividend/divisor        : operation request (master -> slave)
//   out_valid/out_ready/quotient/remainder/div_by_zero : result (slave -> master)
interface restoring_divider_12by6_if;
    import tree_arith_pkg::*;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_12by6_div_step.sv
// div_step: one combinational restoring-division step
//   p_in    : partial remainder before the step
//   bit_in  : next dividend bit, MSB first
//   divisor : denominator
//   p_out   : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module div_step
    import tree_arith_pkg::*;
(
    input  logic [VW:0]   p_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   p_out,
    output logic          q_bit
);
    logic [VW:0] t;
    logic        unused_msb;
    // p_in[VW] is always 0 between steps, so it never reaches t
    assign unused_msb = p_in[VW];
    assign t = {p_in[VW-1:0], bit_in};
    assign q_bit = t >= {1'b0, divisor};
    assign p_out = q_bit ? t - {1'b0, divisor} : t;
endmodule

// File: rtl/restoring_divider_12by6.sv
// restoring_divider_12by6: sequential 12-by-6 unsigned restoring divider, 12 steps per operation
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of restoring_divider_12by6_if (operands in, result out)
module restoring_divider_12by6
    import tree_arith_pkg::*;
(
    input logic clk,
    input logic rst,
    restoring_divider_12by6_if.slave bus
);
    div_state_t    state;
    logic [3:0]    cnt;
    logic [DW-1:0] dvd;
    logic [DW-1:0] quo;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem;
    logic [VW:0]   p;
    logic [VW:0]   p_next;
    logic          q_bit;
    logic          dbz;

    div_step u_step (
        .p_in   (p),
        .bit_in (dvd[DW-1]),
        .divisor(dvs),
        .p_out  (p_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            p     <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dvd <= bus.dividend;
                    dvs <= bus.divisor;
                    cnt <= '0;
                    p   <= '0;
                    if (bus.divisor == '0) begin
                        quo   <= DBZ_QUOT;
                        rem   <= DBZ_REM;
                        dbz   <= 1'b1;
                        state <= DONE;
                    end else begin
                        quo   <= '0;
                        dbz   <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // dividend shifts out MSB first while quotient bits shift in at the LSB
                    p   <= p_next;
                    dvd <= dvd << 1;
                    quo <= {quo[DW-2:0], q_bit};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(DW - 1)) begin
                        rem   <= p_next[VW-1:0];
                        state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: doc/restoring_divider_12by6.md
Name: restoring_divider_12by6

Overview:
- Sequential radix-2 restoring divider: the inverse of the team's 6x6 Wallace multiplier.
- Takes a 12-bit dividend (a full product width) and a 6-bit divisor.
- Returns a 12-bit quotient and a 6-bit remainder after a fixed 12-cycle iteration.
- Sits beside the multiplier in the arithmetic datapath, using valid/ready handshakes on both input and output.

Parameters:
- DW, 12, dividend and quotient width.
- VW, 6, divisor and remainder width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept an operation.
- dividend  input  DW  numerator, unsigned.
- divisor  input  VW  denominator, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  divisor was 0 for this result.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- rst=1 at an edge sets state IDLE and clears internal registers. Outputs then read: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Reset mid-operation (BUSY or DONE) discards the operation and returns to IDLE. No result is produced.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Accept occurs on an edge with in_valid&&in_ready. At accept, dividend and divisor are latched and the step counter is set to 0.
  - divisor!=0: go to BUSY.
  - divisor==0: go to DONE directly, with quotient=12'hFFF, remainder=6'h3F, div_by_zero=1.
- BUSY: in_ready=0, out_valid=0. One restoring step per edge, MSB first:
  - Partial remainder p is 7 bits wide. Form t = {p[5:0], next dividend bit}.
  - If t >= {1'b0,divisor}: p = t - divisor, quotient bit = 1.
  - Else: p = t, quotient bit = 0.
  - Quotient is shifted in from the LSB.
  - After the 12th step the block moves to DONE with remainder = p[5:0] and div_by_zero=0.
- Latency: accept at edge E0. out_valid is first high after edge E12, i.e. 12 cycles. Divide-by-zero results are valid after E0, i.e. 1 cycle.
- Invariant: p[6] is 0 after every step, so remainder < divisor always holds.
- DONE: out_valid=1, in_ready=0. quotient, remainder and div_by_zero stay stable until out_valid&&out_ready at an edge, then the block goes to IDLE.
- Outputs keep their last values in IDLE; their contents are don't-care when out_valid=0.
- No back-to-back overlap: a new accept is possible at the earliest one cycle after the result handshake.
- Changes on dividend and divisor outside the accept edge are ignored.
- in_valid held high during BUSY or DONE is not accepted. The upstream must hold it until in_ready.
- out_ready asserted in IDLE or BUSY has no effect.
- Results are bit-exact: quotient*divisor + remainder == dividend for every nonzero divisor.

Decomposition:
- Shared package tree_arith_pkg holds:
  - localparams DW=12, VW=6;
  - an enum typedef div_state_t {IDLE, BUSY, DONE};
  - constants DBZ_QUOT=12'hFFF and DBZ_REM=6'h3F.
- One combinational sub-module, div_step: inputs p_in[6:0], bit_in, divisor[5:0]; outputs p_out[6:0], q_bit. It is instantiated once and reused every cycle.
- The top holds the FSM, the 4-bit step counter and the shift registers.

Test Plan:
- 4095/63 -> quotient=65, remainder=0, div_by_zero=0, out_valid exactly 12 cycles after accept.
- 100/7 -> quotient=14, remainder=2. Also 2730/1 -> quotient=2730, remainder=0.
- 0/5 -> quotient=0, remainder=0. Also 5/63 -> quotient=0, remainder=5.
- 1234/0 -> out_valid 1 cycle after accept, quotient=12'hFFF, remainder=6'h3F, div_by_zero=1.
- Backpressure:
  - out_ready low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout;
  - the handshake edge returns to IDLE and in_ready=1 on the next cycle;
  - dividend/divisor toggled during BUSY -> result unchanged.
- Reset:
  - rst pulsed at step 6 of 200/9 -> IDLE, out_valid=0, no result;
  - a following 200/9 then gives quotient=22, remainder=2.
- Random: 10k random nonzero-divisor operations checked against quotient*divisor + remainder == dividend and remainder < divisor.
